us_echo_responder: RTL
======================

Name: us_echo_responder

Overview:
- Emulates the sensor end of the ultrasonic trigger/echo interface. It is the counterpart of the pulse generator/detector: it answers a trigger pulse with an echo pulse.
- It accepts the trigger from the detector, validates the minimum trigger width, waits a programmable flight delay, then drives echo_rx high for a programmed number of clk_50M cycles.
- Used for FPGA loopback tests and as a synthesizable bench stimulus for the detector.

Parameters:
- TRIG_MIN, 500, minimum consecutive high trigger samples for a valid trigger (10 us at 50 MHz).
- DELAY_CYCLES, 50, clocks from trigger falling edge to echo rise; legal range >= 1.
- MAX_ECHO, 50000, clamp on echo width in clocks (1 ms).
- HOLDOFF_CYCLES, 1000, clocks after echo fall during which trigger is ignored.

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  trigger pulse from the detector; sampled on posedge.
- echo_width  input  22  requested echo length in clocks; latched at trigger acceptance.
- echo_tx  output  1  echo pulse, to be wired to the detector's echo_rx.
- busy  output  1  high in all states except IDLE.
- done  output  1  one-cycle pulse when the echo sequence finishes.
- trig_err  output  1  one-cycle pulse when a trigger is shorter than TRIG_MIN.
- state  output  3  current FSM state.

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clk_50M.
  - On reset: state=IDLE, echo_tx=0, busy=0, done=0, trig_err=0, all counters and the width latch cleared.
  - Reset mid-operation: echo_tx is 0 after the next edge. No done or trig_err pulse is produced.
- All outputs are registered.
- Every state has a 22-bit counter; the counter clears on state entry.
- State encoding: IDLE=0, ARM=1, DELAY=2, ECHO=3, HOLDOFF=4. Codes 5-7 go to IDLE.
- IDLE:
  - trigger=1 goes to ARM with cnt=1.
- ARM:
  - While trigger=1: cnt increments and saturates at TRIG_MIN.
  - On the first trigger=0 sample with cnt >= TRIG_MIN: latch W = min(echo_width, MAX_ECHO) and go to DELAY.
  - On trigger=0 with cnt < TRIG_MIN: pulse trig_err for 1 cycle and return to IDLE.
  - A trigger held longer than TRIG_MIN is valid; the timing reference is always the falling edge.
- DELAY:
  - Let edge k be the edge at which the falling edge is accepted.
  - echo_tx rises at edge k+DELAY_CYCLES and the state becomes ECHO.
  - If W=0: at that same edge go directly to HOLDOFF, echo_tx stays 0, and done pulses.
- ECHO:
  - echo_tx is high for exactly W clocks and falls at edge k+DELAY_CYCLES+W.
  - done pulses for 1 cycle coincident with the fall. The state becomes HOLDOFF.
- HOLDOFF:
  - Lasts HOLDOFF_CYCLES clocks, then IDLE.
  - A trigger that is high when IDLE is entered starts a new ARM.
- Trigger activity in DELAY, ECHO or HOLDOFF is ignored; no error is flagged.
- echo_width changes after the latch have no effect on the current echo.
- busy = (state != IDLE).
- The width clamp is an unsigned compare; echo_width >= MAX_ECHO yields exactly MAX_ECHO clocks.

Test Plan:
- Nominal 294.2 us echo:
  - Stimulus: reset 2 cycles, trigger high 500 clk, echo_width=14710.
  - Required: echo_tx rises 50 clk after the trigger fall, stays high 14710 clk; done pulses at the fall; busy drops 1000 clk later.
- Width sweep:
  - Stimulus: echo_width = 29410 and 49030 (588.2 us and 980.6 us).
  - Required: echo high-times match exactly; trig_err stays 0.
- Short trigger:
  - Stimulus: trigger high 499 clk.
  - Required: trig_err is a 1-cycle pulse; echo_tx stays 0; state returns to 0.
- Clamp and zero width:
  - Stimulus: echo_width=60000, then echo_width=0.
  - Required: first echo is 50000 clk; second produces no echo, done pulses 50 clk after the trigger fall.
- Retrigger and mid-sequence changes:
  - Stimulus: retrigger during ECHO and during HOLDOFF; change echo_width mid-echo.
  - Required: no effect on the current echo.
- Reset mid-operation:
  - Stimulus: reset asserted in the middle of ECHO.
  - Required: echo_tx=0 and state=0 on the next edge; no done pulse.
- Loopback:
  - Stimulus: connect echo_tx to the detector's echo_rx.
  - Required: detector reports pulses matching echo_width.

Source files
------------

// File: rtl/us_echo_responder.sv
// Ultrasonic sensor emulator: answers a valid trigger pulse with an
// echo pulse of programmable width after a fixed flight delay.
module us_echo_responder #(
    parameter int unsigned TRIG_MIN       = 500,
    parameter int unsigned DELAY_CYCLES   = 50,
    parameter int unsigned MAX_ECHO       = 50000,
    parameter int unsigned HOLDOFF_CYCLES = 1000
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        trigger,
    input  logic [21:0] echo_width,
    output logic        echo_tx,
    output logic        busy,
    output logic        done,
    output logic        trig_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        DELAY   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam logic [21:0] TRIG_C  = 22'(TRIG_MIN);
    localparam logic [21:0] DLY_C   = 22'(DELAY_CYCLES - 1);
    localparam logic [21:0] MAXE_C  = 22'(MAX_ECHO);
    localparam logic [21:0] HOLD_C  = 22'(HOLDOFF_CYCLES - 1);

    state_t      state_q, state_n;
    logic [21:0] cnt_q, cnt_n;
    logic [21:0] w_q, w_n;
    logic        echo_n, done_n, err_n, busy_n;

    assign state = state_q;

    // Next-state, counter, width latch and registered-output values
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        w_n     = w_q;
        echo_n  = echo_tx;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n  = '0;
                echo_n = 1'b0;
                if (trigger) begin
                    state_n = ARM;
                    cnt_n   = 22'd1;
                end
            end
            ARM: begin
                if (trigger) begin
                    if (cnt_q < TRIG_C) cnt_n = cnt_q + 22'd1;
                end else if (cnt_q >= TRIG_C) begin
                    w_n     = (echo_width >= MAXE_C) ? MAXE_C : echo_width;
                    state_n = DELAY;
                    cnt_n   = '0;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            DELAY: begin
                if (cnt_q == DLY_C) begin
                    cnt_n = '0;
                    if (w_q == '0) begin
                        state_n = HOLDOFF;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ECHO;
                        echo_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 22'd1;
                end
            end
            ECHO: begin
                if (cnt_q == w_q - 22'd1) begin
                    echo_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = HOLDOFF;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 22'd1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_C) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 22'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                echo_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, counter, width latch and output registers
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            w_q      <= '0;
            echo_tx  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            w_q      <= w_n;
            echo_tx  <= echo_n;
            busy     <= busy_n;
            done     <= done_n;
            trig_err <= err_n;
        end
    end

endmodule
